// File: rtl/int_ctrl_pkg.sv
// Shared definitions for the eight-source interrupt controller: register
// addresses, FSM encoding, control bit positions and the priority helper.
package int_ctrl_pkg;

    localparam logic [1:0] REG_PEND = 2'd0;
    localparam logic [1:0] REG_MASK = 2'd1;
    localparam logic [1:0] REG_STAT = 2'd2;
    localparam logic [1:0] REG_CTRL = 2'd3;

    localparam int GIE_BIT = 7;
    localparam int EOI_BIT = 0;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } state_e;

    // Lowest set index wins: scanning downwards lets bit 0 overwrite last.
    function automatic logic [2:0] prio_idx(input logic [7:0] vec);
        logic [2:0] idx;
        idx = '0;
        for (int i = 7; i >= 0; i--) begin
            if (vec[i]) idx = 3'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/int_sync_edge.sv
// One interrupt source: multi-flop synchroniser into clk_io followed by a
// registered rising-edge detector producing a single-cycle pulse.
module int_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_io,
    input  logic rst,
    input  logic src_i,
    output logic pulse_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   dly_q;
    logic                   pulse_q;

    // NOTE: every flop here uses <= so the chain shifts one stage per edge;
    // blocking assignments would collapse the synchroniser into one flop.
    always_ff @(posedge clk_io or negedge rst) begin
        if (!rst) begin
            sync_q  <= '0;
            dly_q   <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], src_i};
            dly_q   <= sync_q[SYNC_STAGES-1];
            pulse_q <= sync_q[SYNC_STAGES-1] & ~dly_q;
        end
    end

    assign pulse_o = pulse_q;

endmodule

// File: rtl/int_ctrl.sv
// Interrupt controller top: pending/mask/gie registers on the 2-bit peripheral
// bus, lowest-index priority selection and the IDLE/REQ/SERVICE handshake FSM.
module int_ctrl
    import int_ctrl_pkg::*;
#(
    parameter int NUM_SRC     = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic               clk_io,
    input  logic               rst,
    input  logic [1:0]         rs,
    input  logic               rden,
    input  logic               wren,
    input  logic               en,
    input  logic [7:0]         data_in,
    output logic [7:0]         data_out,
    input  logic [NUM_SRC-1:0] irq_in,
    output logic               irq_req,
    output logic [2:0]         irq_vector,
    input  logic               irq_ack
);

    logic [NUM_SRC-1:0] edge_pulse;
    logic [NUM_SRC-1:0] pend_q, pend_d;
    logic [NUM_SRC-1:0] mask_q, mask_d;
    logic               gie_q, gie_d;
    state_e             state_q, state_d;
    logic [2:0]         vector_q, vector_d;

    logic               wr_en, rd_en, eoi;
    logic [7:0]         pend8, mask8, effective8;
    logic [7:0]         w1c8, ack_clr8;
    logic [7:0]         rdata;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        int_sync_edge #(
            .SYNC_STAGES (SYNC_STAGES)
        ) u_sync_edge (
            .clk_io  (clk_io),
            .rst     (rst),
            .src_i   (irq_in[i]),
            .pulse_o (edge_pulse[i])
        );
    end

    assign wr_en = en & wren;
    assign rd_en = en & rden & ~wren;
    assign eoi   = wr_en && (rs == REG_CTRL) && data_in[EOI_BIT];

    // Registers are widened to the 8-bit bus so unused source bits read 0.
    always_comb begin
        pend8                = '0;
        mask8                = '0;
        pend8[NUM_SRC-1:0]   = pend_q;
        mask8[NUM_SRC-1:0]   = mask_q;
        effective8           = pend8 & mask8 & {8{gie_q}};
    end

    // NOTE: each always_comb assigns every output a default first, so no
    // path through the case/if leaves a signal unassigned (no latches).
    always_comb begin
        state_d  = state_q;
        vector_d = vector_q;
        ack_clr8 = '0;
        unique case (state_q)
            IDLE: begin
                if (|effective8) begin
                    state_d  = REQ;
                    vector_d = prio_idx(effective8);
                end
            end
            REQ: begin
                // Withdrawn by software before the CPU answered: abandon quietly.
                if (!effective8[vector_q]) begin
                    state_d = IDLE;
                end else if (irq_ack) begin
                    state_d            = SERVICE;
                    ack_clr8[vector_q] = 1'b1;
                end
            end
            SERVICE: begin
                if (eoi) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // A fresh edge in the same cycle as any clear leaves the bit set.
    always_comb begin
        w1c8   = (wr_en && (rs == REG_PEND)) ? data_in : 8'h00;
        pend_d = (pend_q & ~(w1c8[NUM_SRC-1:0] | ack_clr8[NUM_SRC-1:0])) | edge_pulse;
        mask_d = (wr_en && (rs == REG_MASK)) ? data_in[NUM_SRC-1:0] : mask_q;
        gie_d  = (wr_en && (rs == REG_CTRL)) ? data_in[GIE_BIT] : gie_q;
    end

    always_ff @(posedge clk_io or negedge rst) begin
        if (!rst) begin
            pend_q   <= '0;
            mask_q   <= '0;
            gie_q    <= 1'b0;
            state_q  <= IDLE;
            vector_q <= '0;
        end else begin
            pend_q   <= pend_d;
            mask_q   <= mask_d;
            gie_q    <= gie_d;
            state_q  <= state_d;
            vector_q <= vector_d;
        end
    end

    assign irq_req    = (state_q == REQ);
    assign irq_vector = vector_q;

    always_comb begin
        rdata = '0;
        unique case (rs)
            REG_PEND: rdata = pend8;
            REG_MASK: rdata = mask8;
            REG_STAT: rdata = {irq_req, (state_q == SERVICE), 3'b000, vector_q};
            REG_CTRL: rdata = {gie_q, 7'b0000000};
            default:  rdata = '0;
        endcase
    end

    assign data_out = rd_en ? rdata : 8'bz;

endmodule

// File: tb/tb_int_ctrl.sv
// Directed bench for int_ctrl: tasks queue expected bus reads / request probes,
// and a negedge monitor pops and compares whenever a sample is presented.
module tb_int_ctrl;
    import int_ctrl_pkg::*;

    localparam int NUM_SRC = 8;

    logic               clk_io  = 1'b0;
    logic               rst     = 1'b0;
    logic [1:0]         rs      = '0;
    logic               rden    = 1'b0;
    logic               wren    = 1'b0;
    logic               en      = 1'b0;
    logic [7:0]         data_in = '0;
    wire  [7:0]         data_out;
    logic [NUM_SRC-1:0] irq_in  = '0;
    logic               irq_req;
    logic [2:0]         irq_vector;
    logic               irq_ack = 1'b0;

    int_ctrl #(
        .NUM_SRC     (NUM_SRC),
        .SYNC_STAGES (2)
    ) dut (
        .clk_io     (clk_io),
        .rst        (rst),
        .rs         (rs),
        .rden       (rden),
        .wren       (wren),
        .en         (en),
        .data_in    (data_in),
        .data_out   (data_out),
        .irq_in     (irq_in),
        .irq_req    (irq_req),
        .irq_vector (irq_vector),
        .irq_ack    (irq_ack)
    );

    always #5 clk_io = ~clk_io;

    typedef enum logic {K_BUS, K_IRQ} kind_e;
    typedef struct {
        string      name;
        kind_e      kind;
        logic [7:0] exp;
    } exp_t;

    exp_t sb[$];
    logic mon_en   = 1'b0;
    int   checks   = 0;
    int   failures = 0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk_io) begin
        if (mon_en) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_underflow: got empty queue expected an entry");
            end else begin
                exp_t       e;
                logic [7:0] act;
                e   = sb.pop_front();
                act = (e.kind == K_IRQ) ? {irq_req, 4'b0000, irq_vector} : data_out;
                check(e.name, act, e.exp);
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk_io);
            #1;
        end
    endtask

    task automatic expect_push(input string name, input kind_e kind, input logic [7:0] exp);
        exp_t e;
        e.name = name;
        e.kind = kind;
        e.exp  = exp;
        sb.push_back(e);
    endtask

    task automatic bus_read(input logic [1:0] addr, input logic [7:0] exp, input string name);
        en = 1'b1; rden = 1'b1; rs = addr; mon_en = 1'b1;
        expect_push(name, K_BUS, exp);
        cyc(1);
        en = 1'b0; rden = 1'b0; mon_en = 1'b0;
    endtask

    task automatic bus_write(input logic [1:0] addr, input logic [7:0] d);
        en = 1'b1; wren = 1'b1; rs = addr; data_in = d;
        cyc(1);
        en = 1'b0; wren = 1'b0; data_in = '0;
    endtask

    task automatic probe_irq(input logic req, input logic [2:0] vec, input string name);
        mon_en = 1'b1;
        expect_push(name, K_IRQ, {req, 4'b0000, vec});
        cyc(1);
        mon_en = 1'b0;
    endtask

    task automatic probe_hiz(input string name);
        en = 1'b0; rden = 1'b1; mon_en = 1'b1;
        expect_push(name, K_BUS, 8'bzzzz_zzzz);
        cyc(1);
        rden = 1'b0; mon_en = 1'b0;
    endtask

    task automatic ack();
        irq_ack = 1'b1;
        cyc(1);
        irq_ack = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        cyc(3);
        rst = 1'b1;

        // Reset state
        bus_read(REG_PEND, 8'h00, "rst_pend");
        bus_read(REG_MASK, 8'h00, "rst_mask");
        bus_read(REG_STAT, 8'h00, "rst_stat");
        bus_read(REG_CTRL, 8'h00, "rst_ctrl");
        probe_irq(1'b0, 3'd0, "rst_irq");
        probe_hiz("hiz_en0");

        // Single source: pending 3 cycles after sampling, request one later
        bus_write(REG_MASK, 8'h04);
        bus_write(REG_CTRL, 8'h80);
        irq_in[2] = 1'b1;
        cyc(3);
        bus_read(REG_PEND, 8'h00, "pend_before_latency");
        bus_read(REG_PEND, 8'h04, "pend_latency");
        probe_irq(1'b1, 3'd2, "req_src2");
        ack();
        bus_read(REG_PEND, 8'h00, "pend_after_ack");
        bus_read(REG_STAT, 8'h42, "stat_service2");
        bus_write(REG_CTRL, 8'h81);
        irq_in[2] = 1'b0;
        bus_read(REG_STAT, 8'h02, "stat_after_eoi");

        // Priority without preemption
        bus_write(REG_MASK, 8'h22);
        irq_in[5] = 1'b1;
        cyc(2);
        irq_in[5] = 1'b0;
        cyc(3);
        probe_irq(1'b1, 3'd5, "req_src5");
        irq_in[1] = 1'b1;
        cyc(2);
        irq_in[1] = 1'b0;
        cyc(2);
        probe_irq(1'b1, 3'd5, "no_preempt");
        bus_read(REG_PEND, 8'h22, "pend_both");
        ack();
        bus_read(REG_STAT, 8'h45, "stat_service5");
        bus_write(REG_CTRL, 8'h81);
        probe_irq(1'b0, 3'd5, "gap_after_eoi");
        probe_irq(1'b1, 3'd1, "req_src1");
        ack();
        bus_write(REG_CTRL, 8'h81);

        // Masking and gie
        bus_write(REG_MASK, 8'h00);
        irq_in[3] = 1'b1;
        cyc(2);
        irq_in[3] = 1'b0;
        cyc(3);
        probe_irq(1'b0, 3'd1, "masked_no_req");
        bus_read(REG_PEND, 8'h08, "pend_masked");
        bus_write(REG_MASK, 8'h08);
        cyc(1);
        probe_irq(1'b1, 3'd3, "unmask_req");
        bus_write(REG_CTRL, 8'h00);
        cyc(1);
        probe_irq(1'b0, 3'd3, "gie_off_idle");
        bus_read(REG_PEND, 8'h08, "pend_kept");
        bus_read(REG_CTRL, 8'h00, "ctrl_gie0");

        // Set beats write-1-to-clear in the same cycle
        irq_in[0] = 1'b1;
        cyc(3);
        bus_write(REG_PEND, 8'h09);
        irq_in[0] = 1'b0;
        bus_read(REG_PEND, 8'h01, "set_beats_w1c");
        bus_write(REG_PEND, 8'h01);
        bus_read(REG_PEND, 8'h00, "w1c");

        // Event during SERVICE stays pending until EOI
        bus_write(REG_MASK, 8'h11);
        bus_write(REG_CTRL, 8'h80);
        irq_in[0] = 1'b1;
        cyc(2);
        irq_in[0] = 1'b0;
        cyc(3);
        ack();
        irq_in[4] = 1'b1;
        cyc(2);
        irq_in[4] = 1'b0;
        cyc(2);
        bus_read(REG_PEND, 8'h10, "pend_in_service");
        probe_irq(1'b0, 3'd0, "no_req_in_service");
        bus_read(REG_STAT, 8'h40, "stat_service0");
        bus_write(REG_CTRL, 8'h81);
        probe_irq(1'b0, 3'd0, "eoi_gap");
        probe_irq(1'b1, 3'd4, "req_after_eoi");

        // Asynchronous reset mid-request, source held through release
        irq_in[6] = 1'b1;
        #2;
        rst = 1'b0;
        probe_irq(1'b0, 3'd0, "async_rst_req");
        cyc(1);
        rst = 1'b1;
        cyc(4);
        bus_read(REG_PEND, 8'h40, "rst_held_src_event");
        bus_read(REG_MASK, 8'h00, "mask_after_rst");
        bus_read(REG_STAT, 8'h00, "stat_after_rst");
        cyc(4);
        bus_write(REG_PEND, 8'h40);
        cyc(4);
        bus_read(REG_PEND, 8'h00, "level_once");
        irq_in[6] = 1'b0;
        cyc(2);

        check("sb_drained", 8'(sb.size()), 8'h00);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/int_ctrl.md
Name: int_ctrl

Overview:
- Eight-source interrupt controller that sits directly downstream of the timers and other peripherals.
- Captures their `interrupt` pulses, which may come from other clock domains such as `clk_tmr`.
- Keeps per-source pending and mask bits and presents one prioritised request with a 3-bit vector to the CPU.
- Register access uses the same 2-bit `rs` / `en` / `rden` / `wren` peripheral bus as the other I/O blocks.

Parameters:
- NUM_SRC, 8: number of interrupt sources; legal range 1..8; unused bits read 0.
- SYNC_STAGES, 2: synchroniser depth per source; minimum 2.

Ports:
- clk_io  in  1  single clock; bus, synchroniser and FSM all run on it.
- rst  in  1  asynchronous, active-low reset.
- rs  in  2  register select.
- rden  in  1  read strobe.
- wren  in  1  write strobe; has priority over rden.
- en  in  1  block select.
- data_in  in  8  write data.
- data_out  out  8  read data; driven while en & rden & !wren, else 8'bz.
- irq_in  in  NUM_SRC  raw source pulses, asynchronous to clk_io.
- irq_req  out  1  interrupt request to the CPU.
- irq_vector  out  3  index of the requesting source; valid while irq_req = 1.
- irq_ack  in  1  CPU acknowledge; sampled only while irq_req = 1.

Behaviour:
- Reset (rst low, asynchronous):
  - pending = 0, mask = 0, gie = 0, all synchroniser and edge flops = 0.
  - state = IDLE, irq_req = 0, irq_vector = 0.
  - Reset mid-request or mid-service aborts immediately with no residue.
- Capture path:
  - Each irq_in bit passes through SYNC_STAGES flops, then a rising-edge detector (sync & ~sync_d).
  - Edge detected → pending[i] set on the next clk_io edge.
  - Latency from the first clk_io edge sampling irq_in high to pending visible: SYNC_STAGES+1 cycles.
  - Sources must stay high ≥ 1 full clk_io period; a level held high counts as one event only.
  - A source already high when rst releases produces one event, because the sync flops reset to 0.
- Register map:
  - rs0 pending: read returns pending; write-1-to-clear.
  - rs1 mask: read/write; 1 = source enabled.
  - rs2 status, read only (writes ignored): [7] = irq_req, [6] = in_service, [5:3] = 0, [2:0] = current/last vector.
  - rs3 control: [7] = gie, read/write. Write with data_in[0] = 1 is EOI (self-clearing, reads 0). Bits [6:1] read 0.
- Read path: data_out is combinational from current register state.
- Clear vs set: if a set and a clear hit the same pending bit in the same cycle (write-1-clear or ack clear), the set wins.
- effective = pending & mask & {NUM_SRC{gie}}.
- Priority: lowest index wins (source 0 highest).
- FSM, states IDLE / REQ / SERVICE:
  - IDLE → REQ when effective ≠ 0. On the transition, latch irq_vector = highest-priority effective index.
    - irq_req rises 1 cycle after effective becomes non-zero.
  - REQ:
    - irq_req = 1; irq_vector holds stable, with no preemption by later higher-priority events.
    - irq_ack = 1 → clear pending[irq_vector], go to SERVICE; irq_req low the next cycle.
    - If gie or mask[vector] goes 0, or pending[vector] is cleared by software, before ack → back to IDLE, irq_req drops, no ack expected.
  - SERVICE: irq_req = 0, in_service = 1. Further events still set pending but are not requested. EOI → IDLE.
    - With effective ≠ 0 at EOI, the next REQ is entered 1 cycle later.
- irq_ack outside REQ: ignored. EOI outside SERVICE: ignored.
- Bus and interrupt events are fully independent; there are no combinational paths from irq_in to any output.

Decomposition:
- Package int_ctrl_pkg holds:
  - register addresses: REG_PEND = 0, REG_MASK = 1, REG_STAT = 2, REG_CTRL = 3;
  - state encoding: IDLE = 2'd0, REQ = 2'd1, SERVICE = 2'd2;
  - bit positions GIE_BIT = 7, EOI_BIT = 0.
- Sub-module int_sync_edge: one source, SYNC_STAGES-deep synchroniser plus rising-edge detect, one-cycle pulse output. Instantiate NUM_SRC times.
- Priority encoder and FSM stay in int_ctrl.

Test Plan:
- Reset check: after reset, read rs0..rs3 → all return 8'h00; irq_req = 0; data_out = z when en = 0.
- Single source: mask = 8'h04, gie = 1; 10-cycle pulse on irq_in[2].
  - pending = 8'h04 exactly 3 cycles after sampling; irq_req = 1 with vector = 2 one cycle later.
  - irq_ack → pending = 0, status = 8'h42; EOI → status = 8'h02.
- Priority, no preemption: pulse irq_in[5], then while in REQ pulse irq_in[1].
  - vector stays 5 until ack. After EOI, REQ reasserts with vector = 1 one cycle later.
- Masking and gie: pending set on bit 3 with mask = 0 → no irq_req.
  - Writing mask = 8'h08 raises irq_req; writing control = 8'h00 in REQ drops irq_req and returns to IDLE; pending[3] remains 1.
- Collisions:
  - Write rs0 = 8'h01 in the same cycle a new source-0 edge sets → pending[0] = 1.
  - Event on source 4 during SERVICE → pending[4] = 1, no irq_req until EOI.
- Async reset mid-REQ: drop rst low asynchronously → irq_req = 0 immediately. A source held high through reset release yields exactly one pending set.
